// File: rtl/dpr_sched_pkg.sv
// Shared constants for the dual-port RAM scheduler: FSM encoding, client
// indices and the width of the optional collision counter.
package dpr_sched_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int CLI0 = 0;
  localparam int CLI1 = 1;

  localparam int COLL_CNT_W = 16;

endpackage

// File: rtl/dpr_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the client that wins the next
// contested cycle and moves to the loser whenever a contest is resolved.
module dpr_rr_arb2
  import dpr_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_ptr;

  always_comb begin
    o_grant = i_req;
    if (&i_req) begin
      o_grant = r_ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_advance && (&i_req)) begin
      r_ptr <= o_grant[CLI0];
    end
  end

endmodule

// File: rtl/dpr_port_scheduler.sv
// Front-end for a true dual-port RAM: sweeps the RAM after reset, then maps
// client 0 to port A and client 1 to port B, serialising same-address
// conflicts round-robin. Optional macro COLLISION_CNT_EN adds collision_cnt.
module dpr_port_scheduler
  import dpr_sched_pkg::*;
#(
  parameter int                  ADDR_SIZE  = 8,
  parameter int                  DATA_SIZE  = 8,
  parameter int                  RAM_SIZE   = 1 << ADDR_SIZE,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 init_done,
  input  logic                 c0_valid,
  input  logic                 c1_valid,
  output logic                 c0_ready,
  output logic                 c1_ready,
  input  logic                 c0_we,
  input  logic                 c1_we,
  input  logic [ADDR_SIZE-1:0] c0_addr,
  input  logic [ADDR_SIZE-1:0] c1_addr,
  input  logic [DATA_SIZE-1:0] c0_wdata,
  input  logic [DATA_SIZE-1:0] c1_wdata,
  output logic                 c0_rsp_valid,
  output logic                 c1_rsp_valid,
  output logic [DATA_SIZE-1:0] c0_rsp_data,
  output logic [DATA_SIZE-1:0] c1_rsp_data,
  output logic                 ram_en_a,
  output logic                 ram_en_b,
  output logic                 ram_we_a,
  output logic                 ram_we_b,
  output logic [ADDR_SIZE-1:0] ram_addr_a,
  output logic [ADDR_SIZE-1:0] ram_addr_b,
  output logic [DATA_SIZE-1:0] ram_din_a,
  output logic [DATA_SIZE-1:0] ram_din_b,
  input  logic [DATA_SIZE-1:0] ram_dout_a,
  input  logic [DATA_SIZE-1:0] ram_dout_b
`ifdef COLLISION_CNT_EN
  ,
  output logic [COLL_CNT_W-1:0] collision_cnt
`endif
);

  localparam logic [ADDR_SIZE-2:0] LAST_PAIR = (ADDR_SIZE-1)'(RAM_SIZE / 2 - 1);

  logic [0:0]           r_state;
  logic [ADDR_SIZE-2:0] r_sweep;
  logic                 r_init_done;
  logic                 r_en_a;
  logic                 r_en_b;
  logic                 r_we_a;
  logic                 r_we_b;
  logic [ADDR_SIZE-1:0] r_addr_a;
  logic [ADDR_SIZE-1:0] r_addr_b;
  logic [DATA_SIZE-1:0] r_din_a;
  logic [DATA_SIZE-1:0] r_din_b;
  logic                 r_rsp_a;
  logic                 r_rsp_b;

  logic       w_run;
  logic       w_coll;
  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic       w_acc0;
  logic       w_acc1;

  // A collision needs a write on either side; read-read to one address is safe.
  assign w_run  = (r_state == ST_RUN);
  assign w_coll = w_run && c0_valid && c1_valid && (c0_addr == c1_addr) && (c0_we || c1_we);
  assign w_req  = {c1_valid, c0_valid} & {2{w_coll}};

  dpr_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_req),
    .i_advance (w_coll),
    .o_grant   (w_grant)
  );

  assign c0_ready = w_run && c0_valid && (!w_coll || w_grant[CLI0]);
  assign c1_ready = w_run && c1_valid && (!w_coll || w_grant[CLI1]);
  assign w_acc0   = c0_valid && c0_ready;
  assign w_acc1   = c1_valid && c1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_sweep     <= '0;
      r_init_done <= 1'b0;
      r_en_a      <= 1'b0;
      r_en_b      <= 1'b0;
      r_we_a      <= 1'b0;
      r_we_b      <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_din_a     <= '0;
      r_din_b     <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_en_a   <= 1'b1;
          r_en_b   <= 1'b1;
          r_we_a   <= 1'b1;
          r_we_b   <= 1'b1;
          r_addr_a <= {r_sweep, 1'b0};
          r_addr_b <= {r_sweep, 1'b1};
          r_din_a  <= INIT_VALUE;
          r_din_b  <= INIT_VALUE;
          if (r_sweep == LAST_PAIR) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        default: begin
          r_en_a <= w_acc0;
          r_we_a <= w_acc0 && c0_we;
          r_en_b <= w_acc1;
          r_we_b <= w_acc1 && c1_we;
          if (w_acc0) begin
            r_addr_a <= c0_addr;
            r_din_a  <= c0_wdata;
          end
          if (w_acc1) begin
            r_addr_b <= c1_addr;
            r_din_b  <= c1_wdata;
          end
        end
      endcase
    end
  end

  // RAM read data arrives one cycle after a read is issued on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_a <= 1'b0;
      r_rsp_b <= 1'b0;
    end else begin
      r_rsp_a <= r_en_a && !r_we_a;
      r_rsp_b <= r_en_b && !r_we_b;
    end
  end

  assign init_done    = r_init_done;
  assign ram_en_a     = r_en_a;
  assign ram_en_b     = r_en_b;
  assign ram_we_a     = r_we_a;
  assign ram_we_b     = r_we_b;
  assign ram_addr_a   = r_addr_a;
  assign ram_addr_b   = r_addr_b;
  assign ram_din_a    = r_din_a;
  assign ram_din_b    = r_din_b;
  assign c0_rsp_valid = r_rsp_a;
  assign c1_rsp_valid = r_rsp_b;
  assign c0_rsp_data  = r_rsp_a ? ram_dout_a : '0;
  assign c1_rsp_data  = r_rsp_b ? ram_dout_b : '0;

`ifdef COLLISION_CNT_EN
  logic [COLL_CNT_W-1:0] r_coll_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll_cnt <= '0;
    end else if (w_coll && (r_coll_cnt != '1)) begin
      r_coll_cnt <= r_coll_cnt + 1'b1;
    end
  end

  assign collision_cnt = r_coll_cnt;
`endif

endmodule

// File: tb/tb_dpr_port_scheduler.sv
// Directed testbench for dpr_port_scheduler with a behavioural dual-port RAM.
module tb_dpr_port_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_done;
  logic       c0_valid, c1_valid, c0_ready, c1_ready, c0_we, c1_we;
  logic [7:0] c0_addr, c1_addr, c0_wdata, c1_wdata;
  logic       c0_rsp_valid, c1_rsp_valid;
  logic [7:0] c0_rsp_data, c1_rsp_data;
  logic       ram_en_a, ram_en_b, ram_we_a, ram_we_b;
  logic [7:0] ram_addr_a, ram_addr_b, ram_din_a, ram_din_b;
  logic [7:0] ram_dout_a, ram_dout_b;
`ifdef COLLISION_CNT_EN
  logic [15:0] collision_cnt;
`endif

  int passCount  = 0;
  int checkCount = 0;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  dpr_port_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_done    (init_done),
    .c0_valid     (c0_valid),
    .c1_valid     (c1_valid),
    .c0_ready     (c0_ready),
    .c1_ready     (c1_ready),
    .c0_we        (c0_we),
    .c1_we        (c1_we),
    .c0_addr      (c0_addr),
    .c1_addr      (c1_addr),
    .c0_wdata     (c0_wdata),
    .c1_wdata     (c1_wdata),
    .c0_rsp_valid (c0_rsp_valid),
    .c1_rsp_valid (c1_rsp_valid),
    .c0_rsp_data  (c0_rsp_data),
    .c1_rsp_data  (c1_rsp_data),
    .ram_en_a     (ram_en_a),
    .ram_en_b     (ram_en_b),
    .ram_we_a     (ram_we_a),
    .ram_we_b     (ram_we_b),
    .ram_addr_a   (ram_addr_a),
    .ram_addr_b   (ram_addr_b),
    .ram_din_a    (ram_din_a),
    .ram_din_b    (ram_din_b),
    .ram_dout_a   (ram_dout_a),
    .ram_dout_b   (ram_dout_b)
`ifdef COLLISION_CNT_EN
    ,
    .collision_cnt(collision_cnt)
`endif
  );

  // Synchronous true dual-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en_a) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      else          ram_dout_a      <= mem[ram_addr_a];
    end
    if (ram_en_b) begin
      if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
      else          ram_dout_b      <= mem[ram_addr_b];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    c0_valid = v; c0_we = we; c0_addr = a; c0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    c1_valid = v; c1_we = we; c1_addr = a; c1_wdata = d;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    drive0(1'b1, 1'b0, 8'h00, 8'h00);
    drive1(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (3) step();
    checkCount++; if (init_done !== 1'b0) $display("[TB] FAIL rst_init_done act=%0b exp=0", init_done); else passCount++;
    checkCount++; if (ram_en_a !== 1'b0 || ram_en_b !== 1'b0) $display("[TB] FAIL rst_ram_en act=%0b%0b exp=00", ram_en_a, ram_en_b); else passCount++;
    checkCount++; if (c0_ready !== 1'b0 || c1_ready !== 1'b0) $display("[TB] FAIL rst_ready act=%0b%0b exp=00", c0_ready, c1_ready); else passCount++;
    rst_n = 1'b1;
    step();
    n = 1;
    checkCount++; if (ram_en_a !== 1'b1 || ram_we_a !== 1'b1 || ram_addr_a !== 8'h00) $display("[TB] FAIL init_first_a en=%0b we=%0b addr=%h exp 1 1 00", ram_en_a, ram_we_a, ram_addr_a); else passCount++;
    checkCount++; if (ram_en_b !== 1'b1 || ram_addr_b !== 8'h01 || ram_din_b !== 8'h00) $display("[TB] FAIL init_first_b en=%0b addr=%h din=%h exp 1 01 00", ram_en_b, ram_addr_b, ram_din_b); else passCount++;
    checkCount++; if (c0_ready !== 1'b0 || c1_ready !== 1'b0) $display("[TB] FAIL init_ready act=%0b%0b exp=00", c0_ready, c1_ready); else passCount++;
    while (!init_done && n < 400) begin
      step();
      n++;
    end
    idle();
    checkCount++; if (n !== 128) $display("[TB] FAIL init_cycles act=%0d exp=128", n); else passCount++;
    checkCount++; if (ram_addr_a !== 8'hFE || ram_addr_b !== 8'hFF) $display("[TB] FAIL init_last_pair act=%h/%h exp=fe/ff", ram_addr_a, ram_addr_b); else passCount++;
  endtask

  task automatic test_init_read();
    drive1(1'b1, 1'b0, 8'h7F, 8'h00);
    #1;
    checkCount++; if (c1_ready !== 1'b1) $display("[TB] FAIL t1_ready act=%0b exp=1", c1_ready); else passCount++;
    step();
    idle();
    checkCount++; if (ram_en_b !== 1'b1 || ram_we_b !== 1'b0 || ram_addr_b !== 8'h7F) $display("[TB] FAIL t1_port_b en=%0b we=%0b addr=%h exp 1 0 7f", ram_en_b, ram_we_b, ram_addr_b); else passCount++;
    step();
    checkCount++; if (c1_rsp_valid !== 1'b1 || c1_rsp_data !== 8'h00) $display("[TB] FAIL t1_rsp valid=%0b data=%h exp 1 00", c1_rsp_valid, c1_rsp_data); else passCount++;
    checkCount++; if (c0_rsp_valid !== 1'b0) $display("[TB] FAIL t1_c0_quiet act=%0b exp=0", c0_rsp_valid); else passCount++;
    step();
    checkCount++; if (c1_rsp_valid !== 1'b0) $display("[TB] FAIL t1_pulse act=%0b exp=0", c1_rsp_valid); else passCount++;
  endtask

  task automatic test_write_read();
    drive0(1'b1, 1'b1, 8'h01, 8'hA1);
    #1;
    checkCount++; if (c0_ready !== 1'b1) $display("[TB] FAIL t2_wr_ready act=%0b exp=1", c0_ready); else passCount++;
    step();
    drive0(1'b1, 1'b0, 8'h01, 8'h00);
    #1;
    checkCount++; if (ram_we_a !== 1'b1 || ram_din_a !== 8'hA1 || ram_addr_a !== 8'h01) $display("[TB] FAIL t2_wr_port we=%0b din=%h addr=%h exp 1 a1 01", ram_we_a, ram_din_a, ram_addr_a); else passCount++;
    step();
    idle();
    checkCount++; if (c0_rsp_valid !== 1'b0) $display("[TB] FAIL t2_wr_no_rsp act=%0b exp=0", c0_rsp_valid); else passCount++;
    checkCount++; if (ram_en_a !== 1'b1 || ram_we_a !== 1'b0) $display("[TB] FAIL t2_rd_port en=%0b we=%0b exp 1 0", ram_en_a, ram_we_a); else passCount++;
    step();
    checkCount++; if (c0_rsp_valid !== 1'b1 || c0_rsp_data !== 8'hA1) $display("[TB] FAIL t2_rsp valid=%0b data=%h exp 1 a1", c0_rsp_valid, c0_rsp_data); else passCount++;
  endtask

  task automatic test_dual_write();
    drive0(1'b1, 1'b1, 8'h11, 8'h16);
    drive1(1'b1, 1'b1, 8'h10, 8'h13);
    #1;
    checkCount++; if (c0_ready !== 1'b1 || c1_ready !== 1'b1) $display("[TB] FAIL t3_ready act=%0b%0b exp=11", c0_ready, c1_ready); else passCount++;
    step();
    idle();
    checkCount++; if (ram_en_a !== 1'b1 || ram_en_b !== 1'b1 || ram_we_a !== 1'b1 || ram_we_b !== 1'b1) $display("[TB] FAIL t3_ports en=%0b%0b we=%0b%0b exp 11 11", ram_en_a, ram_en_b, ram_we_a, ram_we_b); else passCount++;
    step();
    drive0(1'b1, 1'b0, 8'h11, 8'h00);
    drive1(1'b1, 1'b0, 8'h10, 8'h00);
    step();
    idle();
    step();
    checkCount++; if (c0_rsp_valid !== 1'b1 || c0_rsp_data !== 8'h16) $display("[TB] FAIL t3_rsp0 valid=%0b data=%h exp 1 16", c0_rsp_valid, c0_rsp_data); else passCount++;
    checkCount++; if (c1_rsp_valid !== 1'b1 || c1_rsp_data !== 8'h13) $display("[TB] FAIL t3_rsp1 valid=%0b data=%h exp 1 13", c1_rsp_valid, c1_rsp_data); else passCount++;
  endtask

  task automatic test_collision();
    drive0(1'b1, 1'b1, 8'h03, 8'hCC);
    drive1(1'b1, 1'b1, 8'h03, 8'hDD);
    #1;
    checkCount++; if (c0_ready !== 1'b1 || c1_ready !== 1'b0) $display("[TB] FAIL t4_first_win act=%0b%0b exp=10", c0_ready, c1_ready); else passCount++;
    step();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkCount++; if (c1_ready !== 1'b1) $display("[TB] FAIL t4_loser_next act=%0b exp=1", c1_ready); else passCount++;
    checkCount++; if (ram_en_a !== 1'b1 || ram_din_a !== 8'hCC || ram_en_b !== 1'b0) $display("[TB] FAIL t4_port_a en_a=%0b din_a=%h en_b=%0b exp 1 cc 0", ram_en_a, ram_din_a, ram_en_b); else passCount++;
    step();
    idle();
    checkCount++; if (ram_en_b !== 1'b1 || ram_din_b !== 8'hDD || ram_en_a !== 1'b0) $display("[TB] FAIL t4_port_b en_b=%0b din_b=%h en_a=%0b exp 1 dd 0", ram_en_b, ram_din_b, ram_en_a); else passCount++;
    step();
    drive0(1'b1, 1'b0, 8'h03, 8'h00);
    step();
    idle();
    step();
    checkCount++; if (c0_rsp_valid !== 1'b1 || c0_rsp_data !== 8'hDD) $display("[TB] FAIL t4_final1 valid=%0b data=%h exp 1 dd", c0_rsp_valid, c0_rsp_data); else passCount++;
    drive0(1'b1, 1'b1, 8'h03, 8'hCC);
    drive1(1'b1, 1'b1, 8'h03, 8'hDD);
    #1;
    checkCount++; if (c0_ready !== 1'b0 || c1_ready !== 1'b1) $display("[TB] FAIL t4_second_win act=%0b%0b exp=01", c0_ready, c1_ready); else passCount++;
    step();
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkCount++; if (c0_ready !== 1'b1) $display("[TB] FAIL t4_loser2_next act=%0b exp=1", c0_ready); else passCount++;
    step();
    idle();
    step();
    drive1(1'b1, 1'b0, 8'h03, 8'h00);
    step();
    idle();
    step();
    checkCount++; if (c1_rsp_valid !== 1'b1 || c1_rsp_data !== 8'hCC) $display("[TB] FAIL t4_final2 valid=%0b data=%h exp 1 cc", c1_rsp_valid, c1_rsp_data); else passCount++;
  endtask

  task automatic test_read_read();
    drive0(1'b1, 1'b1, 8'h04, 8'h5A);
    step();
    idle();
    step();
    drive0(1'b1, 1'b0, 8'h04, 8'h00);
    drive1(1'b1, 1'b0, 8'h04, 8'h00);
    #1;
    checkCount++; if (c0_ready !== 1'b1 || c1_ready !== 1'b1) $display("[TB] FAIL t5_ready act=%0b%0b exp=11", c0_ready, c1_ready); else passCount++;
    step();
    idle();
    step();
    checkCount++; if (c0_rsp_valid !== 1'b1 || c1_rsp_valid !== 1'b1) $display("[TB] FAIL t5_rsp_valid act=%0b%0b exp=11", c0_rsp_valid, c1_rsp_valid); else passCount++;
    checkCount++; if (c0_rsp_data !== 8'h5A || c1_rsp_data !== 8'h5A) $display("[TB] FAIL t5_rsp_data act=%h/%h exp=5a/5a", c0_rsp_data, c1_rsp_data); else passCount++;
`ifdef COLLISION_CNT_EN
    checkCount++; if (collision_cnt !== 16'd2) $display("[TB] FAIL t5_cnt_rr act=%0d exp=2", collision_cnt); else passCount++;
`endif
    drive0(1'b1, 1'b1, 8'h04, 8'h11);
    drive1(1'b1, 1'b1, 8'h04, 8'h22);
    #1;
    checkCount++; if (c0_ready !== 1'b1 || c1_ready !== 1'b0) $display("[TB] FAIL t5_ptr_kept act=%0b%0b exp=10", c0_ready, c1_ready); else passCount++;
    step();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
`ifdef COLLISION_CNT_EN
    checkCount++; if (collision_cnt !== 16'd3) $display("[TB] FAIL t5_cnt_coll act=%0d exp=3", collision_cnt); else passCount++;
`endif
    step();
    idle();
    step();
  endtask

  task automatic test_reset_abort();
    int n;
    logic sawRsp;
    sawRsp = 1'b0;
    drive0(1'b1, 1'b0, 8'h05, 8'h00);
    step();
    idle();
    checkCount++; if (ram_en_a !== 1'b1 || ram_we_a !== 1'b0) $display("[TB] FAIL t6_outstanding en=%0b we=%0b exp 1 0", ram_en_a, ram_we_a); else passCount++;
    rst_n = 1'b0;
    #1;
    checkCount++; if (init_done !== 1'b0 || ram_en_a !== 1'b0) $display("[TB] FAIL t6_async init_done=%0b en_a=%0b exp 0 0", init_done, ram_en_a); else passCount++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (c0_rsp_valid !== 1'b0) sawRsp = 1'b1;
    end
    rst_n = 1'b1;
    step();
    n = 1;
    if (c0_rsp_valid !== 1'b0) sawRsp = 1'b1;
    checkCount++; if (ram_addr_a !== 8'h00 || ram_addr_b !== 8'h01 || ram_en_a !== 1'b1 || ram_we_a !== 1'b1) $display("[TB] FAIL t6_restart addr=%h/%h en=%0b we=%0b exp 00/01 1 1", ram_addr_a, ram_addr_b, ram_en_a, ram_we_a); else passCount++;
    checkCount++; if (init_done !== 1'b0) $display("[TB] FAIL t6_init_low act=%0b exp=0", init_done); else passCount++;
    while (!init_done && n < 400) begin
      step();
      if (c0_rsp_valid !== 1'b0) sawRsp = 1'b1;
      n++;
    end
    checkCount++; if (sawRsp !== 1'b0) $display("[TB] FAIL t6_dropped_rsp act=%0b exp=0", sawRsp); else passCount++;
    checkCount++; if (n !== 128) $display("[TB] FAIL t6_init_cycles act=%0d exp=128", n); else passCount++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_init_read();
    test_write_read();
    test_dual_write();
    test_collision();
    test_read_read();
    test_reset_abort();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
